// File: rtl/gpu_pixel_sink.sv
// -----------------------------------------------------------------------------
// gpu_pixel_sink
//
// Consumer end of the GPU pixel stream. Accepted pixels go through a small
// skid FIFO, an address stage (linear address = base + y*width + x) and a
// write stage that drives a backpressured 8-bit framebuffer write port. The
// framebuffer is double-buffered: frame_end drains every in-flight pixel of
// the ending frame, then the buffers swap for one cycle (frame_done pulse).
//
// Optional build macro: GPU_PIXEL_SINK_CLIP_EN
//   defined   : pixels with x>=width or y>=height are dropped at the address
//               stage and counted in drop_count (saturating).
//   undefined : no bounds check, drop_count tied to 0.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   pix_color/x/y      pixel beat payload
//   pix_valid          pixel beat valid
//   width, height      frame geometry, sampled with each pixel
//   frame_end          single-cycle end-of-frame pulse
//   out_ready          sink can accept a pixel this cycle
//   fb_wr_addr/data/en framebuffer write request
//   fb_wr_ready        framebuffer accepts the write this cycle
//   front_buffer       buffer index safe for scan-out
//   frame_done         single-cycle pulse on buffer swap
//   pixel_count        writes completed in the current frame
//   drop_count         clipped pixels (saturating)
//   busy               FIFO, a stage, or a swap still pending
//   dbg_state          FSM state (0 RUN, 1 DRAIN, 2 SWAP)
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. The producer holds payload stable while valid is high and ready is
// low; valid never waits on ready. This applies to pix_valid/out_ready and
// fb_wr_en/fb_wr_ready alike.
// -----------------------------------------------------------------------------
module gpu_pixel_sink #(
  parameter int ADDR_W     = 21,
  parameter int FB_SIZE    = 786432,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pix_color,
  input  logic              pix_valid,
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  input  logic [10:0]       width,
  input  logic [10:0]       height,
  input  logic              frame_end,
  output logic              out_ready,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [7:0]        fb_wr_data,
  output logic              fb_wr_en,
  input  logic              fb_wr_ready,
  output logic              front_buffer,
  output logic              frame_done,
  output logic [21:0]       pixel_count,
  output logic [15:0]       drop_count,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]  color;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] w;
    logic [10:0] h;
  } pix_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              back_q, back_d;
  logic              out_ready_q, out_ready_d;
  pix_t              fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              a_valid_q, a_valid_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [7:0]        a_color_q, a_color_d;
  logic              w_valid_q, w_valid_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic [21:0]       pixel_count_q, pixel_count_d;

  // ---------------------------------------------------------------------------
  // FIFO with fall-through: when empty, an accepted beat can be popped into
  // the address stage in the same cycle, which gives the two-cycle latency.
  // ---------------------------------------------------------------------------
  logic              push, pop, fifo_has, w_free, a_ready, wr_done, clipped;
  pix_t              pix_in, head;
  logic [21:0]       prod;
  logic [ADDR_W-1:0] base, addr_sum;

  // Reset masks the registered ready so it is low while reset is held and
  // high on the first cycle after release.
  assign out_ready = out_ready_q & ~reset;
  assign push      = pix_valid & out_ready;
  assign pix_in    = '{color: pix_color, x: pix_x, y: pix_y, w: width, h: height};
  assign head      = (cnt_q == '0) ? pix_in : fifo_mem_q[rd_ptr_q];
  assign fifo_has  = (cnt_q != '0) || push;

  assign w_free    = !w_valid_q || fb_wr_ready;
  assign a_ready   = !a_valid_q || w_free;
  assign pop       = fifo_has && a_ready;
  assign wr_done   = w_valid_q && fb_wr_ready;
  assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);

  assign prod      = 22'(head.y) * 22'(head.w);
  assign base      = back_q ? ADDR_W'(FB_SIZE) : '0;
  assign addr_sum  = base + ADDR_W'(prod) + ADDR_W'(head.x);

`ifdef GPU_PIXEL_SINK_CLIP_EN
  assign clipped = (head.x >= head.w) || (head.y >= head.h);
`else
  // Height only matters when clipping is compiled in.
  logic unused_height;
  assign unused_height = ^head.h;
  assign clipped       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= pix_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Address and write stages
  // ---------------------------------------------------------------------------
  logic drop_inc;

  always_comb begin
    a_valid_d = a_valid_q;
    a_addr_d  = a_addr_q;
    a_color_d = a_color_q;
    drop_inc  = 1'b0;
    if (a_valid_q && w_free) begin
      a_valid_d = 1'b0;
    end
    if (pop) begin
      if (clipped) begin
        drop_inc = 1'b1;
      end else begin
        a_valid_d = 1'b1;
        a_addr_d  = addr_sum;
        a_color_d = head.color;
      end
    end
  end

  always_comb begin
    w_valid_d = w_valid_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    if (w_free) begin
      w_valid_d = a_valid_q;
      if (a_valid_q) begin
        w_addr_d = a_addr_q;
        w_data_d = a_color_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    back_d        = back_q;
    frame_done    = 1'b0;
    pixel_count_d = pixel_count_q + 22'(wr_done);
    case (state_q)
      ST_RUN: begin
        // A pixel accepted alongside frame_end is already in the FIFO and
        // is drained with the ending frame.
        if (frame_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((cnt_q == '0) && !a_valid_q && !w_valid_q) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        back_d        = ~back_q;
        frame_done    = 1'b1;
        pixel_count_d = '0;
        state_d       = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    out_ready_d = (state_d == ST_RUN) && (cnt_d < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      back_q        <= 1'b0;
      out_ready_q   <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      a_valid_q     <= 1'b0;
      a_addr_q      <= '0;
      a_color_q     <= '0;
      w_valid_q     <= 1'b0;
      w_addr_q      <= '0;
      w_data_q      <= '0;
      pixel_count_q <= '0;
    end else begin
      state_q       <= state_d;
      back_q        <= back_d;
      out_ready_q   <= out_ready_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q         <= cnt_d;
      a_valid_q     <= a_valid_d;
      a_addr_q      <= a_addr_d;
      a_color_q     <= a_color_d;
      w_valid_q     <= w_valid_d;
      w_addr_q      <= w_addr_d;
      w_data_q      <= w_data_d;
      pixel_count_q <= pixel_count_d;
    end
  end

`ifdef GPU_PIXEL_SINK_CLIP_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop_inc && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop_inc;
  assign drop_count  = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fb_wr_en     = w_valid_q;
  assign fb_wr_addr   = w_addr_q;
  assign fb_wr_data   = w_data_q;
  assign front_buffer = ~back_q;
  assign pixel_count  = pixel_count_q;
  assign busy         = (cnt_q != '0) || a_valid_q || w_valid_q || (state_q != ST_RUN);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_gpu_pixel_sink.sv
// -----------------------------------------------------------------------------
// tb_gpu_pixel_sink: directed bench for gpu_pixel_sink. Expected framebuffer
// writes are queued when a pixel is accepted and compared, in order, as the
// DUT completes writes. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_gpu_pixel_sink;

  localparam int ADDR_W     = 21;
  localparam int FB_SIZE    = 786432;
  localparam int FIFO_DEPTH = 8;

  logic              clk;
  logic              reset;
  logic [7:0]        pix_color;
  logic              pix_valid;
  logic [10:0]       pix_x, pix_y, width, height;
  logic              frame_end;
  logic              out_ready;
  logic [ADDR_W-1:0] fb_wr_addr;
  logic [7:0]        fb_wr_data;
  logic              fb_wr_en;
  logic              fb_wr_ready;
  logic              front_buffer;
  logic              frame_done;
  logic [21:0]       pixel_count;
  logic [15:0]       drop_count;
  logic              busy;
  logic [1:0]        dbg_state;

  gpu_pixel_sink #(
    .ADDR_W(ADDR_W), .FB_SIZE(FB_SIZE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .pix_color(pix_color), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .width(width), .height(height),
    .frame_end(frame_end), .out_ready(out_ready), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .fb_wr_en(fb_wr_en), .fb_wr_ready(fb_wr_ready),
    .front_buffer(front_buffer), .frame_done(frame_done),
    .pixel_count(pixel_count), .drop_count(drop_count), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  logic [28:0] exp_q[$];
  logic        exp_back = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] mk_exp(input int x, input int y, input logic [7:0] c);
    logic [31:0] a;
    a = (exp_back ? FB_SIZE : 0) + y * 640 + x;
    return {a[20:0], c};
  endfunction

  // Write monitor: in-order compare, plus payload stability while stalled.
  logic        stall_prev = 1'b0;
  logic [28:0] stall_val  = '0;

  always @(negedge clk) begin
    if (fb_wr_en === 1'b1 && stall_prev)
      check("wr_stable", {3'b0, fb_wr_addr, fb_wr_data}, {3'b0, stall_val});
    if (fb_wr_en === 1'b1 && fb_wr_ready === 1'b1) begin
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("wr_addr_data", {3'b0, fb_wr_addr, fb_wr_data}, {3'b0, exp_q.pop_front()});
      stall_prev = 1'b0;
    end else if (fb_wr_en === 1'b1) begin
      stall_prev = 1'b1;
      stall_val  = {fb_wr_addr, fb_wr_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_pix(input int x, input int y, input logic [7:0] c, input bit expect_write);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    pix_x = 11'(x); pix_y = 11'(y); pix_color = c; pix_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (out_ready === 1'b1) begin
        ok = 1'b1;
        if (expect_write) exp_q.push_back(mk_exp(x, y, c));
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 300), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int          px[20], py[20];
  logic [7:0]  pc[20];
  int          acc, fell_at, sent, done_n;
  bit          release_rdy, done_seen, fe_ok;

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    width = 11'd640; height = 11'd480; frame_end = 1'b0; fb_wr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      px[i] = $urandom_range(0, 639);
      py[i] = $urandom_range(0, 479);
      pc[i] = 8'($urandom_range(0, 255));
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_ready", 32'(out_ready), 32'd0);
    check("rst_wr_en", 32'(fb_wr_en), 32'd0);
    check("rst_wr_addr", 32'(fb_wr_addr), 32'd0);
    check("rst_wr_data", 32'(fb_wr_data), 32'd0);
    check("rst_front", 32'(front_buffer), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pixel_count", 32'(pixel_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_out_ready", 32'(out_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'd0);

    // Latency: pixel (3,2,0x5A) accepted in cycle N, written in N+2 at 1283
    @(posedge clk); #1;
    pix_x = 11'd3; pix_y = 11'd2; pix_color = 8'h5A; pix_valid = 1'b1;
    exp_q.push_back(mk_exp(3, 2, 8'h5A));
    @(negedge clk);
    check("lat_accept_n", 32'(out_ready), 32'd1);
    @(posedge clk); #1 pix_valid = 1'b0;
    @(negedge clk);
    check("lat_wr_en_n1", 32'(fb_wr_en), 32'd0);
    @(negedge clk);
    check("lat_wr_en_n2", 32'(fb_wr_en), 32'd1);
    check("lat_addr", 32'(fb_wr_addr), 32'd1283);
    check("lat_data", 32'(fb_wr_data), 32'h5A);
    @(negedge clk);
    check("lat_pixel_count", 32'(pixel_count), 32'd1);

    // Backpressure: 20 pixels with the write port stalled, then released
    @(posedge clk); #1;
    fb_wr_ready = 1'b0;
    acc = 0; fell_at = -1; release_rdy = 1'b0;
    pix_x = 11'(px[0]); pix_y = 11'(py[0]); pix_color = pc[0]; pix_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && acc < 20; cyc++) begin
      @(negedge clk);
      if (out_ready === 1'b1) begin
        exp_q.push_back(mk_exp(px[acc], py[acc], pc[acc]));
        acc++;
      end else if (fell_at < 0) begin
        fell_at = acc;
        release_rdy = 1'b1;
      end
      @(posedge clk); #1;
      if (release_rdy) fb_wr_ready = 1'b1;
      if (acc < 20) begin
        pix_x = 11'(px[acc]); pix_y = 11'(py[acc]); pix_color = pc[acc];
      end
    end
    pix_valid = 1'b0;
    check("bp_ready_fell_after", 32'(fell_at), 32'(FIFO_DEPTH + 2));
    check("bp_all_accepted", 32'(acc), 32'd20);
    wait_idle("bp_drain");
    check("bp_pixel_count", 32'(pixel_count), 32'd21);

    // frame_end with the last pixel, write port toggling
    sent = 0; done_seen = 1'b0; fe_ok = 1'b0;
    @(posedge clk); #1;
    pix_x = 11'd10; pix_y = 11'd1; pix_color = 8'hC0; pix_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        done_seen = 1'b1;
        check("fe_done_after_writes", 32'(exp_q.size()), 32'd0);
      end else begin
        if (pix_valid && out_ready === 1'b1) begin
          exp_q.push_back(mk_exp(int'(pix_x), int'(pix_y), pix_color));
          if (frame_end) fe_ok = 1'b1;
          sent++;
        end
        @(posedge clk); #1;
        fb_wr_ready = ~fb_wr_ready;
        frame_end   = 1'b0;
        if (sent < 4) begin
          pix_x = 11'(10 + sent); pix_y = 11'd1; pix_color = 8'(8'hC0 + sent);
          pix_valid = 1'b1;
          frame_end = (sent == 3);
        end else begin
          pix_valid = 1'b0;
        end
      end
    end
    check("fe_done_seen", 32'(done_seen), 32'd1);
    check("fe_pixel_with_frame_end", 32'(fe_ok), 32'd1);
    @(negedge clk);
    check("fe_front_after", 32'(front_buffer), 32'd0);
    check("fe_count_cleared", 32'(pixel_count), 32'd0);
    check("fe_done_pulse", 32'(frame_done), 32'd0);
    exp_back = 1'b1;
    @(posedge clk); #1 fb_wr_ready = 1'b1;
    send_pix(0, 0, 8'h11, 1'b1);
    wait_idle("fe_next_pixel_drain");
    check("fe_next_pixel_count", 32'(pixel_count), 32'd1);

    // frame_end with an empty pipeline: frame_done two cycles later
    @(posedge clk); #1 frame_end = 1'b1;
    @(negedge clk);
    check("empty_fe_t0", 32'(frame_done), 32'd0);
    @(posedge clk); #1 frame_end = 1'b0;
    @(negedge clk);
    check("empty_fe_t1", 32'(frame_done), 32'd0);
    @(negedge clk);
    check("empty_fe_t2", 32'(frame_done), 32'd1);
    @(negedge clk);
    check("empty_fe_count", 32'(pixel_count), 32'd0);
    check("empty_fe_front", 32'(front_buffer), 32'd1);
    exp_back = 1'b0;

    // Bounds: (640,0), (0,480), (639,479)
`ifdef GPU_PIXEL_SINK_CLIP_EN
    send_pix(640, 0, 8'hA1, 1'b0);
    send_pix(0, 480, 8'hA2, 1'b0);
    send_pix(639, 479, 8'hA3, 1'b1);
    wait_idle("clip_drain");
    check("clip_drop_count", 32'(drop_count), 32'd2);
    check("clip_pixel_count", 32'(pixel_count), 32'd1);
`else
    send_pix(640, 0, 8'hA1, 1'b1);
    send_pix(0, 480, 8'hA2, 1'b1);
    send_pix(639, 479, 8'hA3, 1'b1);
    wait_idle("noclip_drain");
    check("noclip_drop_count", 32'(drop_count), 32'd0);
    check("noclip_pixel_count", 32'(pixel_count), 32'd3);
`endif

    // Reset while draining with four pixels queued
    @(posedge clk); #1 fb_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pix(20 + i, 5, 8'(8'h70 + i), 1'b1);
    @(posedge clk); #1 frame_end = 1'b1;
    @(posedge clk); #1 frame_end = 1'b0;
    @(negedge clk);
    check("drain_state", 32'(dbg_state), 32'd1);
    check("drain_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_drain_wr_en", 32'(fb_wr_en), 32'd0);
    check("rst_drain_busy", 32'(busy), 32'd0);
    check("rst_drain_front", 32'(front_buffer), 32'd1);
    check("rst_drain_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 fb_wr_ready = 1'b1;
    done_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_done === 1'b1) done_n++;
    end
    check("rst_drain_no_frame_done", 32'(done_n), 32'd0);
    check("rst_drain_pixel_count", 32'(pixel_count), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
